// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serial transmitter.
// CPU pushes bytes; the FSM drains them LSB first on o_TX.
module uart_tx_fifo #(
  parameter  int CLKS_PER_BIT = 434,
  parameter  int FIFO_DEPTH   = 16,
  localparam int PTR_W        = $clog2(FIFO_DEPTH),
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1),
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT)
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic [7:0]       i_Data,
  input  logic             i_Write_EN,
  output logic             o_TX,
  output logic             o_UART_Full,
  output logic             o_UART_Busy,
  output logic [CNT_W-1:0] o_Count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  logic [7:0]        r_Mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_Wr_Ptr;
  logic [PTR_W-1:0]  r_Rd_Ptr;
  logic [CNT_W-1:0]  r_Count;

  state_t            r_State;
  logic [BAUD_W-1:0] r_Baud;
  logic [2:0]        r_Bit;
  logic [7:0]        r_Shift;
  logic              r_TX;

  state_t            w_Next_State;
  logic [BAUD_W-1:0] w_Baud_Next;
  logic [2:0]        w_Bit_Next;
  logic [7:0]        w_Shift_Next;
  logic              w_TX_Next;
  logic              w_Pop;
  logic              w_Push;
  logic              w_Full;
  logic              w_Not_Empty;
  logic              w_Baud_Done;
  logic [7:0]        w_Head;

  assign w_Full      = (r_Count == CNT_W'(FIFO_DEPTH));
  assign w_Not_Empty = (r_Count != '0);
  assign w_Head      = r_Mem[r_Rd_Ptr];
  assign w_Baud_Done = (r_Baud == BAUD_W'(CLKS_PER_BIT - 1));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_Push      = i_Write_EN && (!w_Full || w_Pop);

  // Storage array; contents are meaningless once pointers reset.
  always_ff @(posedge i_CLK) begin
    if (w_Push)
      r_Mem[r_Wr_Ptr] <= i_Data;
  end

  // Pointers and occupancy; simultaneous push/pop leaves count unchanged.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_Wr_Ptr <= '0;
      r_Rd_Ptr <= '0;
      r_Count  <= '0;
    end else begin
      if (w_Push)
        r_Wr_Ptr <= r_Wr_Ptr + PTR_W'(1);
      if (w_Pop)
        r_Rd_Ptr <= r_Rd_Ptr + PTR_W'(1);
      unique case ({w_Push, w_Pop})
        2'b10:   r_Count <= r_Count + CNT_W'(1);
        2'b01:   r_Count <= r_Count - CNT_W'(1);
        default: r_Count <= r_Count;
      endcase
    end
  end

  // Transmitter state and datapath registers, o_TX included.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_State <= S_IDLE;
      r_Baud  <= '0;
      r_Bit   <= '0;
      r_Shift <= '0;
      r_TX    <= 1'b1;
    end else begin
      r_State <= w_Next_State;
      r_Baud  <= w_Baud_Next;
      r_Bit   <= w_Bit_Next;
      r_Shift <= w_Shift_Next;
      r_TX    <= w_TX_Next;
    end
  end

  // Next-state logic; the line level is computed alongside the state.
  always_comb begin
    w_Next_State = r_State;
    w_Baud_Next  = r_Baud + BAUD_W'(1);
    w_Bit_Next   = r_Bit;
    w_Shift_Next = r_Shift;
    w_TX_Next    = r_TX;
    w_Pop        = 1'b0;
    unique case (r_State)
      S_IDLE: begin
        w_Baud_Next = '0;
        w_TX_Next   = 1'b1;
        if (w_Not_Empty) begin
          w_Pop        = 1'b1;
          w_Shift_Next = w_Head;
          w_Next_State = S_START;
          w_TX_Next    = 1'b0;
        end
      end
      S_START: begin
        if (w_Baud_Done) begin
          w_Baud_Next  = '0;
          w_Bit_Next   = '0;
          w_Next_State = S_DATA;
          w_TX_Next    = r_Shift[0];
        end
      end
      S_DATA: begin
        if (w_Baud_Done) begin
          w_Baud_Next  = '0;
          w_Shift_Next = {1'b0, r_Shift[7:1]};
          if (r_Bit == 3'd7) begin
            w_Next_State = S_STOP;
            w_TX_Next    = 1'b1;
          end else begin
            w_Bit_Next = r_Bit + 3'd1;
            w_TX_Next  = r_Shift[1];
          end
        end
      end
      S_STOP: begin
        if (w_Baud_Done) begin
          w_Baud_Next = '0;
          if (w_Not_Empty) begin
            w_Pop        = 1'b1;
            w_Shift_Next = w_Head;
            w_Next_State = S_START;
            w_TX_Next    = 1'b0;
          end else begin
            w_Next_State = S_IDLE;
            w_TX_Next    = 1'b1;
          end
        end
      end
      default: begin
        w_Next_State = S_IDLE;
        w_Baud_Next  = '0;
        w_TX_Next    = 1'b1;
      end
    endcase
  end

  assign o_TX        = r_TX;
  assign o_UART_Full = w_Full;
  assign o_UART_Busy = (r_State != S_IDLE) || w_Not_Empty;
  assign o_Count     = r_Count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// A line monitor decodes frames and checks them against queued bytes.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic [7:0]    din;
  logic          wr;
  logic          tx;
  logic          full;
  logic          busy;
  logic [CW-1:0] cnt;

  int n_cmp;
  int n_err;
  int cyc;
  int n_frames;

  logic [7:0] exp_q[$];
  int         starts[$];

  bit         m_act;
  int         m_off;
  int         m_k;
  logic [7:0] m_byte;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_CLK      (clk),
    .i_RESET    (rst),
    .i_Data     (din),
    .i_Write_EN (wr),
    .o_TX       (tx),
    .o_UART_Full(full),
    .o_UART_Busy(busy),
    .o_Count    (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] b);
    din = b;
    wr  = 1'b1;
    tick();
    wr  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && busy; i++)
      tick();
    chk("idle_timeout", 32'(busy), 32'd0);
    repeat (2) tick();
  endtask

  // Line monitor: samples mid-bit, scores each completed frame.
  always @(negedge clk) begin
    if (rst) begin
      m_act = 1'b0;
    end else begin
      if (m_act) begin
        m_off++;
      end else if (tx == 1'b0) begin
        m_act = 1'b1;
        m_off = 0;
        starts.push_back(cyc);
      end
      if (m_act && (m_off % CPB) == CPB / 2) begin
        m_k = m_off / CPB;
        if (m_k == 0) begin
          chk("start_bit", 32'(tx), 32'd0);
        end else if (m_k <= 8) begin
          m_byte[m_k-1] = tx;
        end else begin
          chk("stop_bit", 32'(tx), 32'd1);
          n_frames++;
          if (exp_q.size() == 0)
            chk("extra_frame", 32'(exp_q.size()), 32'd1);
          else
            chk("rx_byte", 32'(m_byte), 32'(exp_q.pop_front()));
        end
      end
      if (m_act && m_off == 10 * CPB - 1)
        m_act = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    int         nf;
    n_cmp    = 0;
    n_err    = 0;
    cyc      = 0;
    n_frames = 0;
    m_act    = 1'b0;
    m_off    = 0;
    rst      = 1'b1;
    wr       = 1'b0;
    din      = 8'h00;
    repeat (3) tick();
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      chk("t1_idle", 32'({tx, busy, full, cnt}),
          32'({1'b1, 1'b0, 1'b0, 3'd0}));
      tick();
    end

    // 2: single byte, exact line pattern
    pat = {1'b1, 8'hA5, 1'b0};
    exp_q.push_back(8'hA5);
    drive(8'hA5);
    chk("t2_cnt1", 32'(cnt), 32'd1);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_tx_pre", 32'(tx), 32'd1);
    tick();
    chk("t2_cnt0", 32'(cnt), 32'd0);
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        chk("t2_line", 32'(tx), 32'(pat[k]));
        chk("t2_busy_hi", 32'(busy), 32'd1);
        tick();
      end
    end
    chk("t2_busy_lo", 32'(busy), 32'd0);
    chk("t2_tx_idle", 32'(tx), 32'd1);
    wait_idle();

    // 3: three consecutive pushes, contiguous frames
    starts.delete();
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i));
      drive(8'(i));
      chk("t3_cnt", 32'(cnt), (i == 3) ? 32'd2 : 32'd1);
    end
    wait_idle();
    chk("t3_frames", 32'(starts.size()), 32'd3);
    for (int i = 1; i < starts.size(); i++)
      chk("t3_gap", 32'(starts[i] - starts[i-1]), 32'(10 * CPB));

    // 4: overflow while a frame is in flight
    nf = n_frames;
    exp_q.push_back(8'h10);
    drive(8'h10);
    repeat (3) tick();
    for (int i = 0; i < 6; i++) begin
      if (i < 4)
        exp_q.push_back(8'(8'h11 + i));
      drive(8'(8'h11 + i));
      chk("t4_cnt", 32'(cnt), (i < 4) ? 32'(i + 1) : 32'd4);
      chk("t4_full", 32'(full), (i >= 3) ? 32'd1 : 32'd0);
    end
    wait_idle();
    chk("t4_frames", 32'(n_frames - nf), 32'd5);

    // 5: push exactly on the pop cycle while full
    nf = n_frames;
    starts.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      drive(8'(8'h20 + i));
    end
    chk("t5_full", 32'(full), 32'd1);
    repeat (36) tick();
    chk("t5_pre_cnt", 32'(cnt), 32'd4);
    chk("t5_pre_tx", 32'(tx), 32'd1);
    exp_q.push_back(8'h25);
    drive(8'h25);
    chk("t5_cnt", 32'(cnt), 32'd4);
    chk("t5_full2", 32'(full), 32'd1);
    chk("t5_tx", 32'(tx), 32'd0);
    wait_idle();
    chk("t5_frames", 32'(n_frames - nf), 32'd6);
    for (int i = 1; i < starts.size(); i++)
      chk("t5_gap", 32'(starts[i] - starts[i-1]), 32'(10 * CPB));

    // 6: asynchronous reset mid-DATA
    exp_q.push_back(8'h00);
    drive(8'h00);
    drive(8'h31);
    drive(8'h32);
    chk("t6_cnt", 32'(cnt), 32'd2);
    repeat (8) tick();
    chk("t6_tx_low", 32'(tx), 32'd0);
    nf = n_frames;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst", 32'({tx, busy, full, cnt}),
        32'({1'b1, 1'b0, 1'b0, 3'd0}));
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      chk("t6_quiet", 32'({tx, busy, cnt}), 32'({1'b1, 1'b0, 3'd0}));
      tick();
    end
    chk("t6_no_frame", 32'(n_frames - nf), 32'd0);
    exp_q.push_back(8'h5A);
    drive(8'h5A);
    wait_idle();
    chk("t6_new_frame", 32'(n_frames - nf), 32'd1);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
